edge_filter_stream: RTL and testbench

EDGE_FILTER_STREAM -- requirements
Module: edge_filter_stream

---
 rtl/edge_filter_pkg.sv | 50 +++++
 rtl/edge_line_buffer.sv | 28 ++
 rtl/edge_filter_stream.sv | 188 ++++++++++++++++++
 tb/tb_edge_filter_stream.sv | 292 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/edge_filter_pkg.sv
// Shared definitions for the 5x5 streaming edge filter: mode encodings,
// kernel tables and accumulator sizing.
package edge_filter_pkg;

    typedef enum logic [1:0] {
        MODE_X   = 2'd0,
        MODE_Y   = 2'd1,
        MODE_LOG = 2'd2,
        MODE_XY  = 2'd3
    } mode_e;

    localparam int KW       = 5;
    localparam int LB_LINES = KW - 1;

    // Row index is the window row (oldest line first), column index the window column.
    localparam int KERN_X [KW][KW] = '{
        '{-1,  -2, 0,  2, 1},
        '{-4,  -8, 0,  8, 4},
        '{-6, -12, 0, 12, 6},
        '{-4,  -8, 0,  8, 4},
        '{-1,  -2, 0,  2, 1}
    };

    localparam int KERN_LOG [KW][KW] = '{
        '{-1, -3, -4, -3, -1},
        '{-3,  0,  6,  0, -3},
        '{-4,  6, 21,  6, -4},
        '{-3,  0,  6,  0, -3},
        '{-1, -3, -4, -3, -1}
    };

    function automatic int acc_width(input int pix_w);
        return pix_w + 8;
    endfunction

    // Primary kernel for the held mode; the Y kernel is the transpose of X.
    function automatic int coef_a(input mode_e m, input int r, input int c);
        case (m)
            MODE_Y:   return KERN_X[c][r];
            MODE_LOG: return KERN_LOG[r][c];
            default:  return KERN_X[r][c];
        endcase
    endfunction

    // Secondary kernel, only non-zero when |X|+|Y| is requested.
    function automatic int coef_b(input mode_e m, input int r, input int c);
        return (m == MODE_XY) ? KERN_X[c][r] : 0;
    endfunction

endpackage

// File: rtl/edge_line_buffer.sv
// Line store for the filter window: one word per column, asynchronous
// read of the old contents with the new word written on the same edge.
module edge_line_buffer
    import edge_filter_pkg::*;
#(
    parameter int DEPTH = 64,
    parameter int WIDTH = 32
) (
    input  logic                     clk,
    input  logic                     wr_en,
    input  logic [$clog2(DEPTH)-1:0] addr,
    input  logic [WIDTH-1:0]         wr_data,
    output logic [WIDTH-1:0]         rd_data
);

    logic [WIDTH-1:0] mem [DEPTH];

    assign rd_data = mem[addr];

    // NOTE: the storage array has no reset; every word is rewritten before
    // it is consumed, so clearing it would only cost logic.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[addr] <= wr_data;
        end
    end

endmodule

// File: rtl/edge_filter_stream.sv
// Streaming 5x5 edge filter (X/Y gradient, LoG, |X|+|Y|) with a
// valid/ready interface and a three-stage, fully stallable pipeline.
module edge_filter_stream
    import edge_filter_pkg::*;
#(
    parameter int PIX_W = 8,
    parameter int IMG_W = 64,
    parameter int SHIFT = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [1:0]       mode,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic             in_sof,
    input  logic [PIX_W-1:0] in_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [PIX_W-1:0] out_data
);

    localparam int         ACC_W    = acc_width(PIX_W);
    localparam int         COL_W    = $clog2(IMG_W);
    localparam int         MAX_PIX  = (1 << PIX_W) - 1;
    localparam logic [2:0] ROW_FULL = 3'd4;

    typedef logic [PIX_W-1:0]        pix_t;
    typedef logic signed [ACC_W-1:0] acc_t;
    typedef logic [ACC_W:0]          mag_t;

    logic                      advance;
    logic                      accept;
    logic [COL_W-1:0]          col;
    logic [COL_W-1:0]          cur_col;
    logic [2:0]                row;
    logic [2:0]                cur_row;
    mode_e                     mode_q;
    mode_e                     mode_eff;
    logic [LB_LINES*PIX_W-1:0] lb_rd;
    logic [LB_LINES*PIX_W-1:0] lb_wr;
    pix_t                      col_vec [KW];
    pix_t                      win     [KW][KW];
    pix_t                      win_n   [KW][KW];
    acc_t                      prod_a   [KW][KW];
    acc_t                      prod_b   [KW][KW];
    acc_t                      prod_a_n [KW][KW];
    acc_t                      prod_b_n [KW][KW];
    acc_t                      row_a;
    acc_t                      row_b;
    acc_t                      acc_a;
    acc_t                      acc_b;
    acc_t                      acc_a_n;
    acc_t                      acc_b_n;
    logic                      s1_valid;
    logic                      s2_valid;
    mag_t                      mag_sum;
    mag_t                      mag_shift;
    pix_t                      sat_pix;

    function automatic acc_t pix_ext(input pix_t p);
        return acc_t'({{(ACC_W-PIX_W){1'b0}}, p});
    endfunction

    function automatic logic [ACC_W-1:0] abs_acc(input acc_t a);
        return a[ACC_W-1] ? -a : a;
    endfunction

    // A held output freezes every stage, so the input side stalls with it.
    assign advance  = ~(out_valid & ~out_ready);
    assign in_ready = advance;
    assign accept   = in_valid & in_ready;

    // A start-of-frame pixel is treated as (0,0) and brings its own mode.
    assign cur_col  = in_sof ? '0 : col;
    assign cur_row  = in_sof ? '0 : row;
    assign mode_eff = in_sof ? mode_e'(mode) : mode_q;

    assign lb_wr = {lb_rd[(LB_LINES-1)*PIX_W-1:0], in_data};

    edge_line_buffer #(
        .DEPTH (IMG_W),
        .WIDTH (LB_LINES*PIX_W)
    ) u_line_buffer (
        .clk     (clk),
        .wr_en   (accept),
        .addr    (cur_col),
        .wr_data (lb_wr),
        .rd_data (lb_rd)
    );

    // NOTE: every combinational output gets a value on every pass through
    // the block, which keeps these always_comb blocks free of latches.
    always_comb begin
        col_vec[KW-1] = in_data;
        for (int k = 0; k < LB_LINES; k++) begin
            col_vec[KW-2-k] = lb_rd[k*PIX_W +: PIX_W];
        end
    end

    // Window as it will look once the current pixel is shifted in.
    always_comb begin
        for (int r = 0; r < KW; r++) begin
            for (int c = 0; c < KW-1; c++) begin
                win_n[r][c] = win[r][c+1];
            end
            win_n[r][KW-1] = col_vec[r];
        end
    end

    always_comb begin
        for (int r = 0; r < KW; r++) begin
            for (int c = 0; c < KW; c++) begin
                prod_a_n[r][c] = pix_ext(win_n[r][c]) * acc_t'(coef_a(mode_eff, r, c));
                prod_b_n[r][c] = pix_ext(win_n[r][c]) * acc_t'(coef_b(mode_eff, r, c));
            end
        end
    end

    // NOTE: blocking assignments are right here because row_a/row_b are
    // scratch sums that must update within the same evaluation.
    always_comb begin
        acc_a_n = '0;
        acc_b_n = '0;
        row_a   = '0;
        row_b   = '0;
        for (int r = 0; r < KW; r++) begin
            row_a = '0;
            row_b = '0;
            for (int c = 0; c < KW; c++) begin
                row_a = row_a + prod_a[r][c];
                row_b = row_b + prod_b[r][c];
            end
            acc_a_n = acc_a_n + row_a;
            acc_b_n = acc_b_n + row_b;
        end
    end

    always_comb begin
        mag_sum   = {1'b0, abs_acc(acc_a)} + {1'b0, abs_acc(acc_b)};
        mag_shift = mag_sum >> SHIFT;
        sat_pix   = (mag_shift > mag_t'(MAX_PIX)) ? pix_t'(MAX_PIX) : mag_shift[PIX_W-1:0];
    end

    // NOTE: sequential state uses non-blocking assignments only, so every
    // stage samples the values its predecessor held before the edge.
    always_ff @(posedge clk) begin
        if (rst) begin
            col       <= '0;
            row       <= '0;
            mode_q    <= mode_e'(mode);
            s1_valid  <= 1'b0;
            s2_valid  <= 1'b0;
            out_valid <= 1'b0;
            out_data  <= '0;
        end else if (advance) begin
            s1_valid  <= accept && (cur_row == ROW_FULL) && (cur_col >= COL_W'(KW-1));
            s2_valid  <= s1_valid;
            out_valid <= s2_valid;
            if (s2_valid) begin
                out_data <= sat_pix;
            end
            if (accept) begin
                mode_q <= mode_eff;
                if (cur_col == COL_W'(IMG_W-1)) begin
                    col <= '0;
                    row <= (cur_row == ROW_FULL) ? ROW_FULL : cur_row + 3'd1;
                end else begin
                    col <= cur_col + COL_W'(1);
                    row <= cur_row;
                end
            end
        end
    end

    // Datapath registers carry no reset; their valids above qualify them.
    always_ff @(posedge clk) begin
        if (accept) begin
            win <= win_n;
        end
        if (advance) begin
            prod_a <= prod_a_n;
            prod_b <= prod_b_n;
            acc_a  <= acc_a_n;
            acc_b  <= acc_b_n;
        end
    end

endmodule

// File: tb/tb_edge_filter_stream.sv
// Directed bench for edge_filter_stream: two instances (SHIFT=4 and SHIFT=0)
// share one stimulus stream and one scoreboard of raw filter magnitudes.
module tb_edge_filter_stream;

    localparam int PIX_W = 8;
    localparam int IMG_W = 8;

    localparam int KX [5][5] = '{
        '{-1,  -2, 0,  2, 1},
        '{-4,  -8, 0,  8, 4},
        '{-6, -12, 0, 12, 6},
        '{-4,  -8, 0,  8, 4},
        '{-1,  -2, 0,  2, 1}
    };
    localparam int KL [5][5] = '{
        '{-1, -3, -4, -3, -1},
        '{-3,  0,  6,  0, -3},
        '{-4,  6, 21,  6, -4},
        '{-3,  0,  6,  0, -3},
        '{-1, -3, -4, -3, -1}
    };

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic [1:0]       mode = 2'd0;
    logic             in_valid = 1'b0;
    logic             in_sof = 1'b0;
    logic [PIX_W-1:0] in_data = '0;
    logic             out_ready = 1'b1;
    logic             in_ready4, in_ready0;
    logic             out_valid4, out_valid0;
    logic [PIX_W-1:0] out_data4, out_data0;

    int               n_assert = 0;
    int               n_fail = 0;
    int               exp_q [$];
    int               log4 [$];
    int               log0 [$];
    int               out_cnt = 0;
    int               stall_cnt = 0;
    int               img [0:15][0:7];
    logic [7:0]       frame [0:7][0:7];
    int               m_row = 0;
    int               m_col = 0;
    logic [1:0]       m_mode = 2'd0;
    logic             prev_stall = 1'b0;
    logic [7:0]       prev_d4, prev_d0;

    always #5 clk = ~clk;

    edge_filter_stream #(.PIX_W(PIX_W), .IMG_W(IMG_W), .SHIFT(4)) u_dut4 (
        .clk(clk), .rst(rst), .mode(mode), .in_valid(in_valid), .in_ready(in_ready4),
        .in_sof(in_sof), .in_data(in_data), .out_valid(out_valid4), .out_ready(out_ready),
        .out_data(out_data4)
    );

    edge_filter_stream #(.PIX_W(PIX_W), .IMG_W(IMG_W), .SHIFT(0)) u_dut0 (
        .clk(clk), .rst(rst), .mode(mode), .in_valid(in_valid), .in_ready(in_ready0),
        .in_sof(in_sof), .in_data(in_data), .out_valid(out_valid0), .out_ready(out_ready),
        .out_data(out_data0)
    );

    task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        n_assert++;
        assert (observed === expected) else begin
            n_fail++;
            $error("FAIL %s: observed %0d, expected %0d", tag, observed, expected);
        end
    endtask

    function automatic int iabs(input int v);
        return (v < 0) ? -v : v;
    endfunction

    function automatic int model_mag(input int r, input int c, input logic [1:0] md);
        int ax = 0;
        int ay = 0;
        int al = 0;
        int p;
        for (int i = 0; i < 5; i++) begin
            for (int j = 0; j < 5; j++) begin
                p  = img[r-4+i][c-4+j];
                ax += KX[i][j] * p;
                ay += KX[j][i] * p;
                al += KL[i][j] * p;
            end
        end
        case (md)
            2'd0:    return iabs(ax);
            2'd1:    return iabs(ay);
            2'd2:    return iabs(al);
            default: return iabs(ax) + iabs(ay);
        endcase
    endfunction

    function automatic int sat_model(input int m, input int sh);
        int v;
        v = m >> sh;
        return (v > 255) ? 255 : v;
    endfunction

    // Output monitor: samples between edges, after the driver has settled.
    always @(negedge clk) begin
        #2;
        if (rst) begin
            prev_stall = 1'b0;
        end else begin
            if (prev_stall) begin
                check("hold_valid", out_valid4, 1);
                check("hold_data4", out_data4, prev_d4);
                check("hold_data0", out_data0, prev_d0);
            end
            if (out_valid4 && !out_ready) begin
                check("in_ready4_stall", in_ready4, 0);
                check("in_ready0_stall", in_ready0, 0);
            end
            if (out_valid4 && out_ready) begin
                if (exp_q.size() == 0) begin
                    check("spurious_out", out_valid4, 0);
                end else begin
                    int m;
                    m = exp_q.pop_front();
                    check("out_valid0", out_valid0, 1);
                    check("out_data4", out_data4, sat_model(m, 4));
                    check("out_data0", out_data0, sat_model(m, 0));
                    log4.push_back(int'(out_data4));
                    log0.push_back(int'(out_data0));
                    out_cnt++;
                end
            end
            prev_stall = out_valid4 && !out_ready;
            prev_d4    = out_data4;
            prev_d0    = out_data0;
        end
    end

    task automatic send_pixel(input logic [7:0] d, input logic sof);
        bit done = 0;
        @(negedge clk);
        in_valid = 1'b1;
        in_data  = d;
        in_sof   = sof;
        for (int t = 0; t < 100 && !done; t++) begin
            out_ready = (stall_cnt == 0);
            if (stall_cnt > 0) stall_cnt--;
            #1;
            if (in_ready4) begin
                @(posedge clk);
                done = 1;
                if (sof) begin
                    m_row  = 0;
                    m_col  = 0;
                    m_mode = mode;
                end
                img[m_row][m_col] = int'(d);
                if (m_row >= 4 && m_col >= 4) exp_q.push_back(model_mag(m_row, m_col, m_mode));
                if (m_col == IMG_W-1) begin
                    m_col = 0;
                    if (m_row < 15) m_row++;
                end else begin
                    m_col++;
                end
            end else begin
                @(negedge clk);
            end
        end
        if (!done) check("accept_timeout", in_ready4, 1);
    endtask

    task automatic fill_frame(input int kind);
        for (int r = 0; r < 8; r++) begin
            for (int c = 0; c < 8; c++) begin
                case (kind)
                    0:       frame[r][c] = 8'd100;
                    1:       frame[r][c] = (c >= 4) ? 8'd16 : 8'd0;
                    2:       frame[r][c] = (r == 4 && c == 4) ? 8'd10 : 8'd0;
                    default: frame[r][c] = 8'($urandom_range(0, 255));
                endcase
            end
        end
    endtask

    task automatic send_frame(input logic [1:0] md, input int n_pix, input bit first_sof,
                              input int stall_at, input int toggle_at, input logic [1:0] toggle_md);
        log4.delete();
        log0.delete();
        out_cnt = 0;
        mode = md;
        for (int i = 0; i < n_pix; i++) begin
            if (i == toggle_at) mode = toggle_md;
            if (i == stall_at) stall_cnt = 5;
            send_pixel(frame[i/IMG_W][i%IMG_W], first_sof && (i == 0));
        end
        @(negedge clk);
        in_valid = 1'b0;
        in_sof   = 1'b0;
    endtask

    task automatic drain(input int exp_count);
        int t = 0;
        out_ready = 1'b1;
        stall_cnt = 0;
        while (exp_q.size() != 0 && t < 200) begin
            @(negedge clk);
            t++;
        end
        check("drain_pending", exp_q.size(), 0);
        repeat (6) @(negedge clk);
        check("frame_outputs", out_cnt, exp_count);
    endtask

    task automatic check_step_row(input string tag, input int base);
        check({tag, "_0"}, log4[base+0], 16);
        check({tag, "_1"}, log4[base+1], 48);
        check({tag, "_2"}, log4[base+2], 48);
        check({tag, "_3"}, log4[base+3], 16);
    endtask

    initial begin
        // Reset state
        repeat (3) @(negedge clk);
        check("rst_out_valid4", out_valid4, 0);
        check("rst_out_data4", out_data4, 0);
        check("rst_out_valid0", out_valid0, 0);
        check("rst_in_ready4", in_ready4, 1);
        rst    = 1'b0;
        m_mode = mode;

        // Flat frame: gradient is zero everywhere
        fill_frame(0);
        send_frame(2'd0, 64, 1, -1, -1, 2'd0);
        drain(16);

        // Vertical step: X gradient profile, Y gradient zero
        fill_frame(1);
        send_frame(2'd0, 64, 1, -1, -1, 2'd0);
        drain(16);
        check_step_row("step_x_row0", 0);
        check_step_row("step_x_row3", 12);
        send_frame(2'd1, 64, 1, -1, -1, 2'd1);
        drain(16);

        // Impulse under LoG, read from the unshifted instance
        fill_frame(2);
        send_frame(2'd2, 64, 1, -1, -1, 2'd2);
        drain(16);
        check("log_centre_4_4", log0[10], 210);
        check("log_centre_4_3", log0[9], 60);
        check("log_centre_2_4", log0[2], 40);

        // Random frames, one with a 5-cycle downstream stall mid-frame
        fill_frame(3);
        send_frame(2'd3, 64, 1, 38, -1, 2'd3);
        drain(16);
        fill_frame(3);
        send_frame(2'd2, 64, 1, 45, -1, 2'd2);
        drain(16);

        // Mid-frame mode change is ignored until the next start of frame
        fill_frame(1);
        send_frame(2'd0, 64, 1, -1, 20, 2'd1);
        drain(16);
        check_step_row("toggle_row0", 0);
        check_step_row("toggle_row3", 12);
        send_frame(2'd1, 64, 1, -1, -1, 2'd1);
        drain(16);
        check("toggle_next_y", log4[5], 0);
        send_frame(2'd3, 64, 1, -1, -1, 2'd3);
        drain(16);
        check_step_row("xy_row1", 4);

        // Reset mid-frame, then a frame without in_sof
        send_frame(2'd0, 20, 1, -1, -1, 2'd0);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        check("midrst_out_valid4", out_valid4, 0);
        check("midrst_out_valid0", out_valid0, 0);
        rst    = 1'b0;
        m_row  = 0;
        m_col  = 0;
        m_mode = mode;
        exp_q.delete();
        send_frame(2'd0, 64, 0, -1, -1, 2'd0);
        drain(16);
        check_step_row("post_rst_row2", 8);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
